// File: rtl/nexys_starship_combo_checker.sv
// Combo checker: collects switch-nibble digits against an offered
// challenge code and reports pass, fail or timeout over valid/ack.
//
// Ports:
//   Clk, Reset_n          clock, async active-low reset
//   Chal_Valid/Code/Ready challenge handshake (first digit in MSBs)
//   Entry_Nibble/Pulse    digit entry from debounced switches/button
//   Clear_Pulse           delete last entered digit
//   Tick                  timebase enable for the entry timeout
//   Abort                 level, returns to IDLE with no result
//   Result_*              result handshake (valid/pass/timeout/ack)
//   Digits_Entered        digits entered so far
//   Entry_Shadow          entered digits, right-aligned
//   q_Idle/Collect/Report one-hot state
module nexys_starship_combo_checker #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 20
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Chal_Valid,
  input  logic [4*DIGITS-1:0] Chal_Code,
  output logic                Chal_Ready,
  input  logic [3:0]          Entry_Nibble,
  input  logic                Entry_Pulse,
  input  logic                Clear_Pulse,
  input  logic                Tick,
  input  logic                Abort,
  output logic                Result_Valid,
  output logic                Result_Pass,
  output logic                Result_Timeout,
  input  logic                Result_Ack,
  output logic [3:0]          Digits_Entered,
  output logic [4*DIGITS-1:0] Entry_Shadow,
  output logic                q_Idle,
  output logic                q_Collect,
  output logic                q_Report
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_COLLECT = 3'b010,
    S_REPORT  = 3'b100
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   chal_q, chal_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     tmo_q, tmo_d;
  logic           pass_q, pass_d;
  logic           tout_q, tout_d;

  logic [W-1:0]   shadow_push;
  logic           entry_ok;

  assign shadow_push = (shadow_q << 4) | W'(Entry_Nibble);
  // Clear wins over a simultaneous entry.
  assign entry_ok = Entry_Pulse & ~Clear_Pulse;

  always_comb begin
    state_d  = state_q;
    chal_d   = chal_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    pass_d   = pass_q;
    tout_d   = tout_q;

    if (Abort) begin
      state_d  = S_IDLE;
      shadow_d = '0;
      cnt_d    = '0;
      tmo_d    = '0;
      pass_d   = 1'b0;
      tout_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Chal_Valid) begin
            state_d  = S_COLLECT;
            chal_d   = Chal_Code;
            shadow_d = '0;
            cnt_d    = '0;
            tmo_d    = '0;
          end
        end
        S_COLLECT: begin
          if (Clear_Pulse) begin
            tmo_d = '0;
            if (cnt_q != 4'd0) begin
              shadow_d = shadow_q >> 4;
              cnt_d    = cnt_q - 4'd1;
            end
          end else if (entry_ok) begin
            // Completion outranks a same-cycle timeout.
            shadow_d = shadow_push;
            cnt_d    = cnt_q + 4'd1;
            tmo_d    = '0;
            if (cnt_q + 4'd1 == 4'(DIGITS)) begin
              state_d = S_REPORT;
              pass_d  = (shadow_push == chal_q);
              tout_d  = 1'b0;
            end
          end else if (Tick) begin
            if (tmo_q == 8'(TIMEOUT - 1)) begin
              state_d = S_REPORT;
              pass_d  = 1'b0;
              tout_d  = 1'b1;
              tmo_d   = '0;
            end else begin
              tmo_d = tmo_q + 8'd1;
            end
          end
        end
        S_REPORT: begin
          if (Result_Ack) begin
            state_d = S_IDLE;
            pass_d  = 1'b0;
            tout_d  = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      chal_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      pass_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      chal_q   <= chal_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      pass_q   <= pass_d;
      tout_q   <= tout_d;
    end
  end

  assign q_Idle         = (state_q == S_IDLE);
  assign q_Collect      = (state_q == S_COLLECT);
  assign q_Report       = (state_q == S_REPORT);
  assign Chal_Ready     = q_Idle;
  assign Result_Valid   = q_Report;
  assign Result_Pass    = pass_q;
  assign Result_Timeout = tout_q;
  assign Digits_Entered = cnt_q;
  assign Entry_Shadow   = shadow_q;

endmodule

// File: tb/tb_nexys_starship_combo_checker.sv
// Directed bench for the combo checker (DIGITS=4, TIMEOUT=3).
// Checks handshakes, compare, clear, timeout, abort and async reset.
module tb_nexys_starship_combo_checker;

  logic        clk;
  logic        rst_n;
  logic        chal_valid;
  logic [15:0] chal_code;
  logic        chal_ready;
  logic [3:0]  nib;
  logic        ent;
  logic        clr;
  logic        tick;
  logic        abort;
  logic        r_valid;
  logic        r_pass;
  logic        r_tmo;
  logic        r_ack;
  logic [3:0]  digits;
  logic [15:0] shadow;
  logic        q_idle;
  logic        q_coll;
  logic        q_rep;

  int n_pass = 0;
  int n_tot  = 0;

  nexys_starship_combo_checker #(
    .DIGITS (4),
    .TIMEOUT(3)
  ) dut (
    .Clk           (clk),
    .Reset_n       (rst_n),
    .Chal_Valid    (chal_valid),
    .Chal_Code     (chal_code),
    .Chal_Ready    (chal_ready),
    .Entry_Nibble  (nib),
    .Entry_Pulse   (ent),
    .Clear_Pulse   (clr),
    .Tick          (tick),
    .Abort         (abort),
    .Result_Valid  (r_valid),
    .Result_Pass   (r_pass),
    .Result_Timeout(r_tmo),
    .Result_Ack    (r_ack),
    .Digits_Entered(digits),
    .Entry_Shadow  (shadow),
    .q_Idle        (q_idle),
    .q_Collect     (q_coll),
    .q_Report      (q_rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] code);
    chal_valid = 1'b1;
    chal_code  = code;
    cyc();
    chal_valid = 1'b0;
    chal_code  = 16'hDEAD;
  endtask

  task automatic enter(input logic [3:0] n);
    nib = n;
    ent = 1'b1;
    cyc();
    ent = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic ack();
    r_ack = 1'b1;
    cyc();
    r_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; chal_valid = 0; chal_code = '0;
    nib = '0; ent = 0; clr = 0; tick = 0;
    abort = 0; r_ack = 0;
    #12;
    chk("rst_idle",   q_idle, 1);
    chk("rst_ready",  chal_ready, 1);
    chk("rst_valid",  r_valid, 0);
    chk("rst_pass",   r_pass, 0);
    chk("rst_tmo",    r_tmo, 0);
    chk("rst_digits", digits, 0);
    chk("rst_shadow", shadow, 0);
    chk("rst_coll",   q_coll, 0);
    #2 rst_n = 1'b1;
    cyc();

    // Correct code A3F0
    offer(16'hA3F0);
    chk("t1_coll",  q_coll, 1);
    chk("t1_ready", chal_ready, 0);
    enter(4'hA); enter(4'h3); enter(4'hF);
    chk("t1_cnt3",   digits, 3);
    chk("t1_novld",  r_valid, 0);
    enter(4'h0);
    chk("t1_valid",  r_valid, 1);
    chk("t1_pass",   r_pass, 1);
    chk("t1_tmo",    r_tmo, 0);
    chk("t1_digits", digits, 4);
    chk("t1_shadow", shadow, 16'hA3F0);
    ack();
    chk("t1_ack_vld", r_valid, 0);
    chk("t1_ack_rdy", chal_ready, 1);
    chk("t1_ack_pas", r_pass, 0);

    // Wrong code, result held without ack
    offer(16'h1234);
    enter(4'h1); enter(4'h2); enter(4'h3); enter(4'h5);
    chk("t2_valid", r_valid, 1);
    chk("t2_pass",  r_pass, 0);
    chk("t2_tmo",   r_tmo, 0);
    ent = 1'b1; nib = 4'h4; clr = 1'b0;
    repeat (100) cyc();
    ent = 1'b0;
    chk("t2_hold_v", r_valid, 1);
    chk("t2_hold_p", r_pass, 0);
    chk("t2_hold_s", shadow, 16'h1235);
    chk("t2_hold_d", digits, 4);
    ack();
    chk("t2_shadow_kept", shadow, 16'h1235);

    // Clear handling
    offer(16'h1234);
    clear();
    chk("t3_clr0_s", shadow, 0);
    chk("t3_clr0_d", digits, 0);
    enter(4'h1); enter(4'h9);
    chk("t3_19", shadow, 16'h0019);
    clear();
    chk("t3_clr_s", shadow, 16'h0001);
    chk("t3_clr_d", digits, 1);
    enter(4'h2); enter(4'h3); enter(4'h4);
    chk("t3_valid",  r_valid, 1);
    chk("t3_pass",   r_pass, 1);
    chk("t3_shadow", shadow, 16'h1234);
    ack();

    // Timeout after exactly 3 ticks
    offer(16'h5678);
    enter(4'h5);
    tk(); tk();
    chk("t4_2tick", r_valid, 0);
    tk();
    chk("t4_valid", r_valid, 1);
    chk("t4_tmo",   r_tmo, 1);
    chk("t4_pass",  r_pass, 0);
    ack();
    chk("t4_ack_tmo", r_tmo, 0);

    // Entry on 2nd tick restarts the count
    offer(16'h5678);
    enter(4'h5);
    tk();
    tick = 1'b1; enter(4'h6); tick = 1'b0;
    tk(); tk();
    chk("t4b_2more", r_valid, 0);
    tk();
    chk("t4b_valid",  r_valid, 1);
    chk("t4b_tmo",    r_tmo, 1);
    chk("t4b_digits", digits, 2);
    ack();

    // Completion and timeout in the same cycle
    offer(16'h5678);
    enter(4'h5); enter(4'h6); enter(4'h7);
    tk(); tk();
    tick = 1'b1; enter(4'h8); tick = 1'b0;
    chk("t4c_valid", r_valid, 1);
    chk("t4c_pass",  r_pass, 1);
    chk("t4c_tmo",   r_tmo, 0);
    ack();

    // Entry+clear same cycle, abort in COLLECT
    offer(16'h1234);
    enter(4'h1); enter(4'h2);
    clr = 1'b1; enter(4'h7); clr = 1'b0;
    chk("t5_both_d", digits, 1);
    chk("t5_both_s", shadow, 16'h0001);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t5_ab_idle", q_idle, 1);
    chk("t5_ab_vld",  r_valid, 0);
    chk("t5_ab_d",    digits, 0);
    chk("t5_ab_s",    shadow, 0);
    cyc();
    chk("t5_ab_vld2", r_valid, 0);

    // Abort in REPORT
    offer(16'h1111);
    enter(4'h1); enter(4'h1); enter(4'h1); enter(4'h1);
    chk("t5_rep_vld", r_valid, 1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t5_rab_vld",  r_valid, 0);
    chk("t5_rab_pass", r_pass, 0);
    chk("t5_rab_idle", q_idle, 1);

    // Async reset mid-COLLECT
    offer(16'hBEEF);
    enter(4'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_idle",  q_idle, 1);
    chk("t6_ready", chal_ready, 1);
    chk("t6_coll",  q_coll, 0);
    chk("t6_d",     digits, 0);
    chk("t6_s",     shadow, 0);
    #3 rst_n = 1'b1;
    cyc();
    offer(16'hC0DE);
    chk("t6_resume", q_coll, 1);
    enter(4'hC); enter(4'h0); enter(4'hD); enter(4'hE);
    chk("t6_pass", r_pass, 1);
    chk("t6_vld",  r_valid, 1);
    ack();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/nexys_starship_combo_checker.md
# nexys_starship_combo_checker

Responder side of the repair-combo challenge. A repair state machine offers a hex challenge code over a valid/ready handshake. This block collects the player's digits from the switch nibble on each debounced entry pulse, then reports pass, fail or timeout over a valid/ack handshake. It sits between the repair state machines (TR/BR/LR/RR) and the debounced button/switch inputs, and exports the entered digits for the SSD scanner.

## Interface
- DIGITS, 4, number of hex digits per challenge (legal 1..8)
- TIMEOUT, 20, Tick pulses allowed between entries before timeout (legal 1..255)

- Clk  in  1  system clock (100 MHz sys_clk)
- Reset_n  in  1  asynchronous, active-low reset
- Chal_Valid  in  1  challenge offered
- Chal_Code  in  4*DIGITS  challenge; first digit expected is bits [4*DIGITS-1 -: 4]
- Chal_Ready  out  1  block can accept a challenge
- Entry_Nibble  in  4  {Sw3,Sw2,Sw1,Sw0}
- Entry_Pulse  in  1  single-cycle debounced pulse; enter the current nibble
- Clear_Pulse  in  1  single-cycle debounced pulse; delete the last digit
- Tick  in  1  single-cycle timebase enable (DIV_CLK[24] edge)
- Abort  in  1  level; gameover_ctrl
- Result_Valid  out  1  result available
- Result_Pass  out  1  entered code equals challenge
- Result_Timeout  out  1  result caused by timeout
- Result_Ack  in  1  consumer accepts the result
- Digits_Entered  out  4  count of digits entered so far
- Entry_Shadow  out  4*DIGITS  entered digits, right-aligned; unentered digits are 0
- q_Idle, q_Collect, q_Report  out  1 each  one-hot state

## Operation
- States: IDLE, COLLECT, REPORT.
- Reset: state IDLE, Chal_Ready=1, and every other output 0. The challenge register and the timeout counter are cleared.
- IDLE: Chal_Ready=1. When Chal_Valid=1, latch Chal_Code and clear the count, Entry_Shadow and the timeout counter. The next state is COLLECT. Entry_Pulse and Clear_Pulse are ignored in IDLE.
- COLLECT:
  - Entry_Pulse: Entry_Shadow <= {Entry_Shadow[4*DIGITS-5:0], Entry_Nibble}. Count increments and the timeout counter clears.
  - Clear_Pulse: Entry_Shadow shifts right by 4. Count decrements and the timeout counter clears. Clear_Pulse at count 0 is a no-op, but it still clears the timeout counter.
  - Entry_Pulse and Clear_Pulse in the same cycle: Clear wins and the entry is dropped.
  - On the edge where the count reaches DIGITS, the next state is REPORT. Result_Pass = (shadow including the final nibble == challenge) and Result_Timeout=0.
  - Each Tick increments the timeout counter. If a Tick arrives while the counter is at TIMEOUT-1 and no entry or clear occurs in that cycle, the next state is REPORT with Result_Pass=0 and Result_Timeout=1.
  - If an entry completes the code in the same cycle as the timeout, the completed code is reported and the timeout is not.
- REPORT:
  - Result_Valid=1, with Result_Pass and Result_Timeout held stable.
  - When Result_Ack=1, the next state is IDLE and all Result_* outputs drop to 0.
  - Entry_Pulse and Clear_Pulse are ignored in REPORT.
  - Entry_Shadow holds its value until the next challenge is accepted.
- Abort=1 has priority over everything in every state. The next state is IDLE and the Result_* outputs go to 0. No result is produced for an aborted challenge. Entry_Shadow and the count clear.
- Comparison is an exact 4*DIGITS-bit equality, and the compare result is registered.

## Timing
- All outputs are registered, and the q_* outputs match the state register.
- Handshake to COLLECT: handshake at edge N gives q_Collect=1 and Chal_Ready=0 after edge N. Chal_Code is sampled only at edge N.
- Entry: a pulse sampled at edge N updates Entry_Shadow and Digits_Entered after edge N.
- Final digit at edge N: Result_Valid=1 after edge N. Completion-to-result latency is 1 cycle.
- Ack at edge N: Result_Valid=0 and Chal_Ready=1 after edge N. A new challenge can be accepted at edge N+1 at the earliest.
- Timeout fires exactly TIMEOUT Ticks after the last counter clear.
- Reset_n assertion mid-operation forces the reset values immediately and asynchronously. Release is synchronous to Clk.

## Test plan
- DIGITS=4. Challenge 16'hA3F0 accepted. Entries A,3,F,0 give Result_Valid=1 and Result_Pass=1 one cycle after the 4th pulse. Digits_Entered=4 and Entry_Shadow=16'hA3F0. Ack returns to IDLE with Chal_Ready=1.
- Challenge 16'h1234, entries 1,2,3,5 → Result_Pass=0, Result_Timeout=0. Result holds with Result_Ack=0 for 100 cycles.
- Challenge 16'h1234: entries 1,9, Clear, then 2,3,4 → Entry_Shadow after the Clear =16'h0001 and final Result_Pass=1. Clear at count 0 leaves Entry_Shadow=0.
- TIMEOUT=3: challenge accepted, one entry, then 3 Ticks → Result_Valid=1, Result_Timeout=1, Result_Pass=0. An entry on the 2nd Tick restarts the count, so 3 more Ticks are needed.
- Entry_Pulse and Clear_Pulse in the same cycle at count 2 → count becomes 1 and the nibble is dropped. Abort in COLLECT → IDLE next cycle, no Result_Valid. Abort in REPORT → Result_Valid=0 next cycle.
- Reset_n pulsed low mid-COLLECT between clock edges → q_Idle=1, Chal_Ready=1 and other outputs 0 immediately. After release, normal handshake resumes.
